// File: rtl/datapath_pipe.sv
// Two-stage register-file datapath: operand read with forwarding, ALU/shift and
// result select in the first stage; EX/WB register commits to the file on the next edge.
module datapath_pipe #(
  parameter int W    = 4,
  parameter int NREG = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            valid,
  input  logic            nWE,
  input  logic [AW-1:0]   DA,
  input  logic [AW-1:0]   AA,
  input  logic [AW-1:0]   BA,
  input  logic            MB,
  input  logic [3:0]      FS,
  input  logic            MD,
  input  logic [W-1:0]    const_in,
  input  logic [W-1:0]    data_in,
  output logic [W-1:0]    F_out,
  output logic            C,
  output logic            V,
  output logic            N,
  output logic            Z,
  output logic            wb_pending,
  output logic [NREG*W-1:0] regs_flat
);

  logic [W-1:0]  rf_q [NREG];
  logic [W-1:0]  rf_d [NREG];
  logic [W-1:0]  f_q, f_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic          wb_pending_q, wb_pending_d;
  logic          c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

  logic [W-1:0]  a_op, b_reg, b_op;
  logic [W-1:0]  addend;
  logic          cin, arith;
  logic [W:0]    sum;
  logic [W-1:0]  res;
  logic          c_res, v_res;

  // The EX/WB entry is the newest value of its register until it commits.
  always_comb begin
    a_op  = (wb_pending_q && wb_addr_q == AA) ? f_q : rf_q[AA];
    b_reg = (wb_pending_q && wb_addr_q == BA) ? f_q : rf_q[BA];
    b_op  = MB ? const_in : b_reg;
  end

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    arith  = 1'b0;
    res    = a_op;
    c_res  = 1'b0;
    v_res  = 1'b0;
    case (FS)
      4'b0001: begin addend = '0;    cin = 1'b1; arith = 1'b1; end
      4'b0010: begin addend = b_op;  cin = 1'b0; arith = 1'b1; end
      4'b0011: begin addend = b_op;  cin = 1'b1; arith = 1'b1; end
      4'b0100: begin addend = ~b_op; cin = 1'b0; arith = 1'b1; end
      4'b0101: begin addend = ~b_op; cin = 1'b1; arith = 1'b1; end
      4'b0110: begin addend = '1;    cin = 1'b0; arith = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, a_op} + {1'b0, addend} + {{W{1'b0}}, cin};
    if (arith) begin
      res   = sum[W-1:0];
      c_res = sum[W];
      v_res = (a_op[W-1] == addend[W-1]) && (res[W-1] != a_op[W-1]);
    end else begin
      case (FS)
        4'b1000: res = a_op & b_op;
        4'b1001: res = a_op | b_op;
        4'b1010: res = a_op ^ b_op;
        4'b1011: res = ~a_op;
        4'b1100: res = b_op;
        4'b1101: begin res = b_op >> 1; c_res = b_op[0];   end
        4'b1110: begin res = b_op << 1; c_res = b_op[W-1]; end
        4'b1111: res = b_op;
        default: res = a_op;
      endcase
    end
  end

  always_comb begin
    wb_pending_d = valid & ~nWE;
    wb_addr_d    = wb_addr_q;
    f_d          = f_q;
    c_d          = c_q;
    v_d          = v_q;
    n_d          = n_q;
    z_d          = z_q;
    if (valid) begin
      wb_addr_d = DA;
      f_d       = MD ? data_in : res;
      if (!MD) begin
        c_d = c_res;
        v_d = v_res;
        n_d = res[W-1];
        z_d = (res == '0);
      end
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_pending_q) rf_d[wb_addr_q] = f_q;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      f_q          <= '0;
      wb_addr_q    <= '0;
      wb_pending_q <= 1'b0;
      c_q          <= 1'b0;
      v_q          <= 1'b0;
      n_q          <= 1'b0;
      z_q          <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      f_q          <= f_d;
      wb_addr_q    <= wb_addr_d;
      wb_pending_q <= wb_pending_d;
      c_q          <= c_d;
      v_q          <= v_d;
      n_q          <= n_d;
      z_q          <= z_d;
    end
  end

  assign F_out      = f_q;
  assign C          = c_q;
  assign V          = v_q;
  assign N          = n_q;
  assign Z          = z_q;
  assign wb_pending = wb_pending_q;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
      assign regs_flat[gi*W +: W] = rf_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: a W=4/NREG=4 and a W=8/NREG=8 instance share one stimulus
// stream; each is checked against an architectural model and directed expectations.
module tb_datapath_pipe;

  logic        clk = 1'b0;
  logic        nRST;
  logic        valid, nWE, MB, MD;
  logic [2:0]  DA, AA, BA;
  logic [3:0]  FS;
  logic [7:0]  const_in, data_in;

  logic [3:0]  f4;  logic c4, v4, n4, z4, p4;  logic [15:0] rf4;
  logic [7:0]  f8;  logic c8, v8, n8, z8, p8;  logic [63:0] rf8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  datapath_pipe #(.W(4), .NREG(4)) dut4 (
    .clk(clk), .nRST(nRST), .valid(valid), .nWE(nWE),
    .DA(DA[1:0]), .AA(AA[1:0]), .BA(BA[1:0]), .MB(MB), .FS(FS), .MD(MD),
    .const_in(const_in[3:0]), .data_in(data_in[3:0]),
    .F_out(f4), .C(c4), .V(v4), .N(n4), .Z(z4), .wb_pending(p4), .regs_flat(rf4)
  );

  datapath_pipe #(.W(8), .NREG(8)) dut8 (
    .clk(clk), .nRST(nRST), .valid(valid), .nWE(nWE),
    .DA(DA), .AA(AA), .BA(BA), .MB(MB), .FS(FS), .MD(MD),
    .const_in(const_in), .data_in(data_in),
    .F_out(f8), .C(c8), .V(v8), .N(n8), .Z(z8), .wb_pending(p8), .regs_flat(rf8)
  );

  // Architectural model: mrf is the register view seen by the next issued op,
  // mcm is what regs_flat must show (the view as of one edge earlier).
  int         mw[2]  = '{4, 8};
  int         mnr[2] = '{4, 8};
  logic [7:0] mrf[2][8];
  logic [7:0] mcm[2][8];
  logic [7:0] mf[2];
  logic       mc[2], mv[2], mn[2], mz[2], mp[2];

  function automatic void ref_alu(input int w, input int fs, input int a, input int b,
                                  output int r, output bit c, output bit v);
    int m, half, x, cin, sum, sa, sx, s;
    bit ar;
    m = (1 << w) - 1;
    half = 1 << (w - 1);
    x = 0; cin = 0; ar = 1'b1;
    r = a; c = 1'b0; v = 1'b0;
    case (fs)
      1: begin x = 0;        cin = 1; end
      2: begin x = b;        cin = 0; end
      3: begin x = b;        cin = 1; end
      4: begin x = ~b & m;   cin = 0; end
      5: begin x = ~b & m;   cin = 1; end
      6: begin x = m;        cin = 0; end
      default: ar = 1'b0;
    endcase
    if (ar) begin
      sum = a + x + cin;
      r = sum & m;
      c = ((sum >> w) & 1) != 0;
      sa = (a >= half) ? a - (1 << w) : a;
      sx = (x >= half) ? x - (1 << w) : x;
      s = sa + sx + cin;
      v = (s > half - 1) || (s < -half);
    end else begin
      case (fs)
        8:  r = a & b;
        9:  r = a | b;
        10: r = a ^ b;
        11: r = ~a & m;
        12, 15: r = b;
        13: begin r = b >> 1; c = (b & 1) != 0; end
        14: begin r = (b << 1) & m; c = ((b >> (w - 1)) & 1) != 0; end
        default: r = a;
      endcase
    end
  endfunction

  task automatic mdl_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 8; i++) begin mrf[j][i] = '0; mcm[j][i] = '0; end
      mf[j] = '0; mc[j] = 0; mv[j] = 0; mn[j] = 0; mz[j] = 0; mp[j] = 0;
    end
  endtask

  task automatic mdl_edge();
    int m, a, b, r, da;
    bit c, v;
    for (int j = 0; j < 2; j++) begin
      m = (1 << mw[j]) - 1;
      for (int i = 0; i < 8; i++) mcm[j][i] = mrf[j][i];
      mp[j] = valid && !nWE;
      if (valid) begin
        a  = int'(mrf[j][int'(AA) % mnr[j]]);
        b  = MB ? (int'(const_in) & m) : int'(mrf[j][int'(BA) % mnr[j]]);
        da = int'(DA) % mnr[j];
        ref_alu(mw[j], int'(FS), a, b, r, c, v);
        if (MD) begin
          mf[j] = 8'(int'(data_in) & m);
        end else begin
          mf[j] = 8'(r);
          mc[j] = c; mv[j] = v; mn[j] = ((r >> (mw[j] - 1)) & 1) != 0; mz[j] = (r == 0);
        end
        if (!nWE) mrf[j][da] = mf[j];
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input bit v, input bit nwe, input int da_i, input int aa_i,
                      input int ba_i, input bit mb_i, input int fs_i, input bit md_i,
                      input int k_i, input int d_i);
    valid = v; nWE = nwe; MB = mb_i; MD = md_i;
    DA = da_i[2:0]; AA = aa_i[2:0]; BA = ba_i[2:0]; FS = fs_i[3:0];
    const_in = k_i[7:0]; data_in = d_i[7:0];
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
  endtask

  task automatic load(input int da_i, input int d_i);
    step(1, 0, da_i, 0, 0, 0, 0, 1, 0, d_i);
  endtask

  task automatic test_reset();
    load(1, 9);
    load(2, 6);
    // Pending write to R2 must vanish when reset drops between edges.
    nRST = 1'b0;
    #1;
    mdl_reset();
    checks++;
    if (rf4 !== 16'h0 || rf8 !== 64'h0) begin
      failures++;
      $display("FAIL reset_async_regs: got rf4=%h rf8=%h want 0", rf4, rf8);
    end
    checks++;
    if ({f4, c4, v4, n4, z4, p4} !== 9'h0 || {f8, c8, v8, n8, z8, p8} !== 13'h0) begin
      failures++;
      $display("FAIL reset_async_out: got f4=%h f8=%h flags4=%b flags8=%b p4=%b p8=%b want 0",
               f4, f8, {c4, v4, n4, z4}, {c8, v8, n8, z8}, p4, p8);
    end
    @(negedge clk);
    nRST = 1'b1;
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf4 !== 16'h0 || rf8 !== 64'h0 || p4 !== 1'b0 || p8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_commit: got rf4=%h rf8=%h p4=%b p8=%b want 0", rf4, rf8, p4, p8);
    end
  endtask

  task automatic test_load_dependent();
    load(1, 3);
    checks++;
    if (f4 !== 4'd3 || p4 !== 1'b1) begin
      failures++;
      $display("FAIL load_fout: got F=%0d pend=%b want F=3 pend=1", f4, p4);
    end
    step(1, 0, 2, 1, 1, 0, 4'b0010, 0, 0, 0);
    checks++;
    if (f4 !== 4'd6 || rf4[7:4] !== 4'd3) begin
      failures++;
      $display("FAIL dep_add_fwd: got F=%0d R1=%0d want F=6 R1=3", f4, rf4[7:4]);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf4[11:8] !== 4'd6 || f8 !== 8'd6) begin
      failures++;
      $display("FAIL dep_add_commit: got R2=%0d F8=%0d want R2=6 F8=6", rf4[11:8], f8);
    end
  endtask

  task automatic test_wrap();
    load(1, 15);
    step(1, 0, 3, 1, 0, 0, 4'b0001, 0, 0, 0);
    checks++;
    if (f4 !== 4'd0 || {c4, z4, n4, v4} !== 4'b1100) begin
      failures++;
      $display("FAIL wrap_inc: got F=%0d CZNV=%b want F=0 CZNV=1100", f4, {c4, z4, n4, v4});
    end
  endtask

  task automatic test_overflow();
    load(1, 7);
    step(1, 0, 3, 1, 0, 1, 4'b0010, 0, 1, 0);
    checks++;
    if (f4 !== 4'd8 || {v4, n4, c4, z4} !== 4'b1100) begin
      failures++;
      $display("FAIL signed_ovf: got F=%0d VNCZ=%b want F=8 VNCZ=1100", f4, {v4, n4, c4, z4});
    end
    // A load must leave the flags from the previous arithmetic untouched.
    load(0, 0);
    checks++;
    if (f4 !== 4'd0 || {v4, n4, c4, z4} !== 4'b1100) begin
      failures++;
      $display("FAIL load_holds_flags: got F=%0d VNCZ=%b want F=0 VNCZ=1100", f4, {v4, n4, c4, z4});
    end
  endtask

  task automatic test_sub_shift();
    load(1, 5);
    load(2, 7);
    step(1, 0, 3, 1, 2, 0, 4'b0101, 0, 0, 0);
    checks++;
    if (f4 !== 4'd14 || c4 !== 1'b0 || n4 !== 1'b1) begin
      failures++;
      $display("FAIL sub: got F=%0d C=%b N=%b want F=14 C=0 N=1", f4, c4, n4);
    end
    step(1, 0, 3, 0, 2, 0, 4'b1101, 0, 0, 0);
    checks++;
    if (f4 !== 4'd3 || c4 !== 1'b1 || v4 !== 1'b0) begin
      failures++;
      $display("FAIL shr: got F=%0d C=%b V=%b want F=3 C=1 V=0", f4, c4, v4);
    end
  endtask

  task automatic test_sweep8();
    logic [63:0] snap;
    load(7, 8'hA5);
    step(1, 0, 7, 7, 0, 1, 4'b1010, 0, 8'hFF, 0);
    checks++;
    if (f8 !== 8'h5A) begin
      failures++;
      $display("FAIL xor8_fout: got %h want 5a", f8);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf8[63:56] !== 8'h5A) begin
      failures++;
      $display("FAIL xor8_commit: got R7=%h want 5a", rf8[63:56]);
    end
    snap = rf8;
    step(0, 0, 7, 0, 0, 0, 0, 1, 0, 8'h11);
    checks++;
    if (rf8 !== snap || p8 !== 1'b0 || f8 !== 8'h5A) begin
      failures++;
      $display("FAIL bubble8: got rf=%h pend=%b F=%h want rf=%h pend=0 F=5a", rf8, p8, f8, snap);
    end
    step(1, 1, 7, 0, 0, 0, 0, 1, 0, 8'h22);
    checks++;
    if (p8 !== 1'b0 || f8 !== 8'h22) begin
      failures++;
      $display("FAIL nwe8_out: got pend=%b F=%h want pend=0 F=22", p8, f8);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rf8 !== snap) begin
      failures++;
      $display("FAIL nwe8_regs: got %h want %h", rf8, snap);
    end
  endtask

  task automatic test_random();
    logic [7:0] gf, gr;
    logic [4:0] gfl;
    int nerr;
    for (int t = 0; t < 400; t++) begin
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 99) < 20,
           $urandom_range(0, 255), $urandom_range(0, 255));
      for (int j = 0; j < 2; j++) begin
        gf  = (j == 0) ? {4'b0, f4} : f8;
        gfl = (j == 0) ? {c4, v4, n4, z4, p4} : {c8, v8, n8, z8, p8};
        checks++;
        if (gf !== mf[j] || gfl !== {mc[j], mv[j], mn[j], mz[j], mp[j]}) begin
          failures++;
          $display("FAIL rand_out w=%0d op=%0d: got F=%h CVNZP=%b want F=%h CVNZP=%b",
                   mw[j], t, gf, gfl, mf[j], {mc[j], mv[j], mn[j], mz[j], mp[j]});
        end
        nerr = 0;
        for (int i = 0; i < mnr[j]; i++) begin
          gr = (j == 0) ? {4'b0, rf4[i*4 +: 4]} : rf8[i*8 +: 8];
          if (gr !== mcm[j][i]) begin
            nerr++;
            if (nerr == 1)
              $display("FAIL rand_reg w=%0d op=%0d R%0d: got %h want %h", mw[j], t, i, gr, mcm[j][i]);
          end
        end
        checks++;
        if (nerr != 0) failures++;
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    valid = 0; nWE = 1; MB = 0; MD = 0; DA = 0; AA = 0; BA = 0; FS = 0;
    const_in = 0; data_in = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    test_reset();
    test_load_dependent();
    test_wrap();
    test_overflow();
    test_sub_shift();
    test_sweep8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, two-stage successor to the 4-bit register-file/function-unit datapath. Holds `NREG` general registers of `W` bits and executes one micro-operation per cycle: operand read, optional constant substitution, ALU/shift, and data-in or result selection. The result and status flags are registered in an execute/write-back (EX/WB) stage and committed to the register file on the following edge. Single-level forwarding makes back-to-back dependent operations stall-free. It sits under the control unit and above memory/IO, in place of the fixed 4×4 datapath.

## Interface
- `W`, 4: data width in bits, ≥2.
- `NREG`, 4: number of registers, a power of two ≥2. The address width `AW = $clog2(NREG)` is a derived localparam.

- `clk`  in  1  — single clock; all state changes on the rising edge.
- `nRST`  in  1  — reset, asynchronous and active-low.
- `valid`  in  1  — issue strobe; the control fields below are sampled only when 1.
- `nWE`  in  1  — register write enable, active-low.
- `DA`  in  AW  — destination register address.
- `AA`  in  AW  — A operand address.
- `BA`  in  AW  — B operand address.
- `MB`  in  1  — 1 selects `const_in` as the B operand; 0 selects register B.
- `FS`  in  4  — function select.
- `MD`  in  1  — 1 writes `data_in`; 0 writes the function result.
- `const_in`  in  W  — constant operand.
- `data_in`  in  W  — external load data.
- `F_out`  out  W  — registered EX/WB write data.
- `C`, `V`, `N`, `Z`  out  1 each  — registered status flags.
- `wb_pending`  out  1  — EX/WB holds a write not yet committed.
- `regs_flat`  out  NREG*W  — all registers; register i is at bits `[i*W +: W]`.

## Operation
- Operand A = forwarded RF[AA]. Operand B = `const_in` if `MB`, else forwarded RF[BA].
- Forwarding: if `wb_pending` and the EX/WB address equals AA (or BA), use EX/WB data instead of the RF read.
- Result width rules:
  - Arithmetic is computed at W+1 bits. `C` = bit W of that sum.
  - `V` = signed overflow (operand MSBs equal, result MSB different).
  - All results wrap modulo 2^W.
- FS encoding:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A−B (A+~B+1)
  - 0110 A−1 (A+all-ones)
  - 0111 A
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B
  - 1101 B>>1 (logical shift, `C` = B[0])
  - 1110 B<<1 (`C` = B[W-1])
  - 1111 B
- Flags for logic ops and 1100/1111: `C`=0, `V`=0. For shifts: `V`=0.
- `N` = result MSB and `Z` = (result==0) for every FS.
- Issue with `valid`=1:
  - EX/WB captures data (`data_in` if `MD`, else the result), DA, and write = ~`nWE`.
  - Flags update only when `MD`=0; on a load (`MD`=1) flags hold.
  - `F_out` always updates.
- Issue with `valid`=0: EX/WB write bit clears (bubble). `F_out` and flags hold.
- Commit: on every edge where `wb_pending`=1, RF[EX/WB addr] ← EX/WB data. Any register, including R0, is writable.

## Timing
- Reset (`nRST` low, takes effect immediately):
  - All registers = 0, so `regs_flat` = 0.
  - `F_out` = 0, `C`=`V`=`N`=`Z`=0, `wb_pending` = 0.
- Reset asserted mid-operation discards the pending write; no commit occurs on the release edge.
- Latency: an issue sampled at edge t gives `F_out`/flags valid after t and the RF/`regs_flat` update after t+1.
- Back-to-back dependency: the op issued at t+1 sees the t result through forwarding. Rate is one op per cycle, with no stall.
- Simultaneous commit and issue to the same DA: the newer issue enters EX/WB and the older write commits. The final value is the newer one, one edge later.
- `nWE`=1 with `valid`=1: flags and `F_out` update; no register write.

## Test plan
- Reset: hold `nRST`=0 mid-stream, then release → `regs_flat`=0, `F_out`=0, flags 0, `wb_pending`=0; the first edge after release commits nothing.
- Load then dependent add (W=4): load R1←3 (`MD`=1), next cycle R2←R1+R1 (FS=0010) → `F_out`=6 one edge after issue; R2=6 in `regs_flat` two edges after issue, with no bubble.
- Wrap-around: R1=15, FS=0001 → result 0, `C`=1, `Z`=1, `N`=0, `V`=0.
- Signed overflow: R1=7, `const_in`=1, `MB`=1, FS=0010 → 8, `V`=1, `N`=1, `C`=0.
- Subtract and shift: R1=5, R2=7, FS=0101 → 14, `C`=0, `N`=1. Then FS=1101 with BA=R2 → 3, `C`=1.
- Parameter sweep at W=8, NREG=8:
  - Write R7←0xA5, then R7←R7^0xFF → R7=0x5A.
  - Issue with `valid`=0 and with `nWE`=1 → `regs_flat` unchanged.
